// File: rtl/isr_arb_pkg.sv
// isr_arb_pkg
//   Shared constants for the ISR arbiter slice: operand/result widths of the
//   integer square root unit and the arbiter FSM state encoding.
//   No ports (package).
package isr_arb_pkg;

    localparam int ISR_IN_W  = 64;
    localparam int ISR_OUT_W = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_LOAD = 2'd1;
    localparam arb_state_t ST_WAIT = 2'd2;
    localparam arb_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/isr_rr_pick.sv
// isr_rr_pick
//   Combinational round-robin picker. Searches req starting one position
//   after the last granted index (wrapping) and returns the first hit.
//   The last-grant pointer register lives in the parent.
// Ports
//   req       in   NUM_REQ  pending requests
//   last_gnt  in   ID_W     index granted most recently
//   pick_gnt  out  NUM_REQ  one-hot winner (zero when no request)
//   pick_idx  out  ID_W     index of the winner
//   pick_any  out  1        at least one request present
module isr_rr_pick
    import isr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [NUM_REQ-1:0] pick_gnt,
    output logic [ID_W-1:0]    pick_idx,
    output logic               pick_any
);

    // Walk the requesters in priority order last_gnt+1, last_gnt+2, ...
    // and keep only the first one found, so the result is always one-hot.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand     = '0;
        pick_gnt = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!pick_any && req[cand]) begin
                pick_any       = 1'b1;
                pick_idx       = cand;
                pick_gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/isr_arbiter.sv
// isr_arbiter
//   Shares one 64-bit integer square root (ISR) unit among NUM_REQ clients.
//   A round-robin pick grants one requester, its operand is loaded into the
//   ISR by holding isr_reset high for one cycle, the arbiter waits for
//   isr_done and returns the 32-bit root tagged with the requester id.
// Configuration
//   ISR_ARB_WDOG_EN  when defined, WAIT gives up after WDOG_CYC cycles and
//                    returns resp_err=1 with resp_result=0. When undefined
//                    WAIT waits forever and resp_err is tied low.
// Ports
//   clock        in   1             system clock
//   reset        in   1             synchronous, active-high
//   req          in   NUM_REQ       request, held with operand until gnt
//   req_value    in   NUM_REQ*64    packed operands, requester i at [64i +: 64]
//   gnt          out  NUM_REQ       one-hot single-cycle accept pulse
//   resp_valid   out  1             single-cycle response pulse
//   resp_id      out  ID_W          requester owning the response
//   resp_result  out  32            floor(sqrt(operand))
//   resp_err     out  1             watchdog abort flag
//   busy         out  1             high whenever not IDLE
//   isr_reset    out  1             ISR reset / load strobe
//   isr_value    out  64            ISR operand
//   isr_result   in   32            ISR root
//   isr_done     in   1             ISR completion
module isr_arbiter
    import isr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int WDOG_CYC = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*ISR_IN_W-1:0]  req_value,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [ISR_OUT_W-1:0]         resp_result,
    output logic                         resp_err,
    output logic                         busy,
    output logic                         isr_reset,
    output logic [ISR_IN_W-1:0]          isr_value,
    input  logic [ISR_OUT_W-1:0]         isr_result,
    input  logic                         isr_done
);

    arb_state_t           state;
    logic [ID_W-1:0]      last_gnt;
    logic [ISR_IN_W-1:0]  op_value;
    logic [ID_W-1:0]      op_id;
    logic [ISR_OUT_W-1:0] op_result;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;

    logic [ISR_IN_W-1:0]  req_op [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign req_op[g] = req_value[g*ISR_IN_W +: ISR_IN_W];
    end

    isr_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .pick_gnt (pick_gnt),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

`ifdef ISR_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_expired;
    logic              op_err;

    // Counts WAIT cycles of the current operation; expiry fires on the
    // last of WDOG_CYC waiting cycles so RESP follows exactly WDOG_CYC
    // cycles after WAIT was entered.
    assign wdog_expired = (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (state == ST_LOAD) begin
            wdog_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign resp_err = op_err;
`else
    // WDOG_CYC only matters with the watchdog built in; keep it referenced.
    logic wdog_param_unused;
    assign wdog_param_unused = (WDOG_CYC != 0);

    assign resp_err = 1'b0;
`endif

    // Main sequencer. Reset starts the pointer at NUM_REQ-1 so requester 0
    // has the highest priority on the first pick after reset, and drops any
    // in-flight operation without producing a response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            last_gnt  <= ID_W'(NUM_REQ - 1);
            op_value  <= '0;
            op_id     <= '0;
            op_result <= '0;
`ifdef ISR_ARB_WDOG_EN
            op_err    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        op_value <= req_op[pick_idx];
                        op_id    <= pick_idx;
                        last_gnt <= pick_idx;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (isr_done) begin
                        op_result <= isr_result;
`ifdef ISR_ARB_WDOG_EN
                        op_err    <= 1'b0;
`endif
                        state     <= ST_RESP;
                    end
`ifdef ISR_ARB_WDOG_EN
                    else if (wdog_expired) begin
                        op_result <= '0;
                        op_err    <= 1'b1;
                        state     <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Grants are only offered in IDLE and never while reset is applied.
    assign gnt         = (state == ST_IDLE && !reset) ? pick_gnt : '0;
    assign busy        = (state != ST_IDLE);
    assign resp_valid  = (state == ST_RESP);
    assign resp_id     = op_id;
    assign resp_result = op_result;
    // The ISR is held in reset (loading isr_value) outside WAIT.
    assign isr_reset   = reset || (state != ST_WAIT);
    assign isr_value   = op_value;

endmodule

// File: tb/tb_isr_arbiter.sv
// tb_isr_arbiter
//   Self-checking bench for isr_arbiter. A behavioural ISR responder with a
//   programmable latency answers load/compute cycles; expected grants,
//   response timing and roots are derived from the arbitration rules and
//   integer arithmetic.
module tb_isr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WDOG    = 64;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*64-1:0]  req_value;
    logic [NUM_REQ-1:0]     gnt;
    logic                   resp_valid;
    logic [ID_W-1:0]        resp_id;
    logic [31:0]            resp_result;
    logic                   resp_err;
    logic                   busy;
    logic                   isr_reset;
    logic [63:0]            isr_value;
    logic [31:0]            isr_result;
    logic                   isr_done;

    int checks = 0;
    int errors = 0;

    int          isr_lat     = 0;
    bit          isr_stall   = 1'b0;
    int          isr_cnt     = 0;
    logic [63:0] isr_latched = '0;

    always #5 clock = ~clock;

    isr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W),
        .WDOG_CYC (WDOG)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_value   (req_value),
        .gnt         (gnt),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .busy        (busy),
        .isr_reset   (isr_reset),
        .isr_value   (isr_value),
        .isr_result  (isr_result),
        .isr_done    (isr_done)
    );

    // Largest r with r*r <= v, by binary search on wide products.
    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [32:0] lo, hi, mid;
        logic [65:0] sq;
        lo = '0;
        hi = 33'h1_0000_0000;
        while (hi - lo > 33'd1) begin
            mid = (lo + hi) >> 1;
            sq  = {33'b0, mid} * {33'b0, mid};
            if (sq <= {2'b0, v}) lo = mid;
            else                 hi = mid;
        end
        return lo[31:0];
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'($urandom_range(0, 1000));
            3: begin r = $urandom; return {32'b0, r} * {32'b0, r}; end
            4: begin r = $urandom; return ({32'b0, r} * {32'b0, r}) - 64'd1; end
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ISR responder: loads while isr_reset is high; once released, raises
    // isr_done after isr_lat further cycles (0 = in the first released cycle).
    always @(negedge clock) begin
        if (isr_reset) begin
            isr_latched = isr_value;
            isr_cnt     = 0;
            isr_done    = 1'b0;
        end else begin
            isr_done   = !isr_stall && (isr_cnt >= isr_lat);
            isr_result = isqrt(isr_latched);
            isr_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_val(input int i, input logic [63:0] v);
        req_value[i*64 +: 64] = v;
    endtask

    task automatic reset_dut();
        next_cycle();
        reset = 1'b1;
        req   = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Returns the number of cycles until resp_valid is seen, or -1.
    task automatic wait_resp(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            next_cycle();
            @(negedge clock);
            if (resp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_val(i, {$urandom, $urandom});
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_resp_id got %0d want 0", resp_id); end
        checks++; if (resp_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_resp_result got %h want 0", resp_result); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (isr_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_isr_reset got %b want 1", isr_reset); end
        checks++; if (isr_value !== 64'd0) begin errors++; $display("[TB] FAIL reset_isr_value got %h want 0", isr_value); end
        next_cycle();
        reset = 1'b0;
        req   = '0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("[TB] FAIL idle_after_reset got busy=%b gnt=%b want 0/0000", busy, gnt); end
    endtask

    task automatic test_single();
        int n;
        reset_dut();
        isr_lat = 2;
        next_cycle();
        set_val(0, 64'd225);
        req = 4'b0001;
        @(negedge clock);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt got %b want 0001", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_grant got %b want 0", busy); end
        next_cycle();
        req = '0;
        @(negedge clock);
        checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_load_state got gnt=%b busy=%b want 0000/1", gnt, busy); end
        checks++; if (isr_reset !== 1'b1 || isr_value !== 64'd225) begin errors++; $display("[TB] FAIL single_load_isr got rst=%b val=%0d want 1/225", isr_reset, isr_value); end
        next_cycle();
        @(negedge clock);
        checks++; if (isr_reset !== 1'b0 || isr_value !== 64'd225) begin errors++; $display("[TB] FAIL single_wait_isr got rst=%b val=%0d want 0/225", isr_reset, isr_value); end
        wait_resp(40, n);
        checks++; if (n != isr_lat + 1) begin errors++; $display("[TB] FAIL single_latency got %0d want %0d", n, isr_lat + 1); end
        checks++; if (resp_id !== 2'd0 || resp_result !== 32'd15 || resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL single_resp got id=%0d res=%0d err=%b want 0/15/0", resp_id, resp_result, resp_err); end
        next_cycle();
        @(negedge clock);
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_after_resp got rv=%b busy=%b want 0/0", resp_valid, busy); end
    endtask

    task automatic test_all_req();
        logic [63:0] vals [4] = '{64'd100, 64'd200, 64'd300, 64'd0};
        logic [31:0] want [4] = '{32'd10, 32'd14, 32'd17, 32'd0};
        int          gorder [$];
        int          rid [$];
        logic [31:0] rres [$];
        logic [3:0]  pend;
        int          cyc;
        int          got_g, got_id;
        logic [31:0] got_r;
        bit          stray;
        reset_dut();
        isr_lat = 1;
        pend = 4'b1111;
        for (int k = 0; k < 4; k++) set_val(k, vals[k]);
        cyc = 0;
        while (rid.size() < 4 && cyc < 100) begin
            next_cycle();
            req = pend;
            @(negedge clock);
            cyc++;
            for (int b = 0; b < 4; b++) if (gnt[b]) gorder.push_back(b);
            pend = pend & ~gnt;
            if (resp_valid) begin
                rid.push_back(int'(resp_id));
                rres.push_back(resp_result);
            end
        end
        checks++; if (rid.size() != 4) begin errors++; $display("[TB] FAIL allreq_resp_count got %0d want 4", rid.size()); end
        checks++; if (gorder.size() != 4) begin errors++; $display("[TB] FAIL allreq_gnt_count got %0d want 4", gorder.size()); end
        for (int k = 0; k < 4; k++) begin
            got_g  = (k < gorder.size()) ? gorder[k] : -1;
            got_id = (k < rid.size()) ? rid[k] : -1;
            got_r  = (k < rres.size()) ? rres[k] : 32'hDEAD_BEEF;
            checks++; if (got_g != k) begin errors++; $display("[TB] FAIL allreq_order[%0d] got %0d want %0d", k, got_g, k); end
            checks++; if (got_id != k || got_r !== want[k]) begin
                errors++; $display("[TB] FAIL allreq_resp[%0d] got id=%0d res=%0d want %0d/%0d", k, got_id, got_r, k, want[k]); end
        end
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            req = '0;
            @(negedge clock);
            if (resp_valid || gnt != 4'b0000) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("[TB] FAIL allreq_extra_activity got 1 want 0"); end
    endtask

    task automatic test_max();
        int n;
        isr_lat = 3;
        next_cycle();
        set_val(2, 64'hFFFF_FFFF_FFFF_FFFF);
        req = 4'b0100;
        @(negedge clock);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL max_gnt got %b want 0100", gnt); end
        next_cycle();
        req = '0;
        wait_resp(40, n);
        checks++; if (n < 0 || resp_id !== 2'd2 || resp_result !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL max_resp got n=%0d id=%0d res=%h want id=2 res=ffffffff", n, resp_id, resp_result); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit stray;
        reset_dut();
        isr_lat = 20;
        next_cycle();
        set_val(0, 64'd1000);
        req = 4'b0001;
        @(negedge clock);
        next_cycle();
        req = '0;
        repeat (3) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0 || isr_reset !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_state got busy=%b isr_reset=%b rv=%b want 0/1/0", busy, isr_reset, resp_valid); end
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            next_cycle();
            @(negedge clock);
            if (resp_valid || busy) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("[TB] FAIL midreset_stray_resp got 1 want 0"); end
        isr_lat = 1;
        next_cycle();
        set_val(1, 64'd49);
        req = 4'b0010;
        @(negedge clock);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL midreset_gnt got %b want 0010", gnt); end
        next_cycle();
        req = '0;
        wait_resp(40, n);
        checks++; if (n < 0 || resp_id !== 2'd1 || resp_result !== 32'd7) begin
            errors++; $display("[TB] FAIL midreset_resp got n=%0d id=%0d res=%0d want id=1 res=7", n, resp_id, resp_result); end
    endtask

    task automatic test_held_while_busy();
        int          c, n_resp, resp_c, g3_c;
        logic [3:0]  gval;
        int          id0, id1;
        logic [31:0] r0, r1;
        reset_dut();
        isr_lat = 3;
        next_cycle();
        set_val(1, 64'd81);
        req = 4'b0010;
        @(negedge clock);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL held_first_gnt got %b want 0010", gnt); end
        next_cycle();
        set_val(3, 64'd144);
        req = 4'b1000;
        c = 1; n_resp = 0; resp_c = -1; g3_c = -1; gval = '0;
        id0 = -1; id1 = -1; r0 = '0; r1 = '0;
        while (c <= 40 && n_resp < 2) begin
            @(negedge clock);
            if (resp_valid) begin
                if (n_resp == 0) begin resp_c = c; id0 = int'(resp_id); r0 = resp_result; end
                else begin id1 = int'(resp_id); r1 = resp_result; end
                n_resp++;
            end
            if (gnt != 4'b0000 && g3_c < 0) begin g3_c = c; gval = gnt; end
            next_cycle();
            c++;
            if (g3_c >= 0) req = '0;
        end
        checks++; if (resp_c != 3 + isr_lat) begin errors++; $display("[TB] FAIL held_resp_cycle got %0d want %0d", resp_c, 3 + isr_lat); end
        checks++; if (g3_c != resp_c + 1 || gval !== 4'b1000) begin
            errors++; $display("[TB] FAIL held_second_gnt got cyc=%0d gnt=%b want cyc=%0d gnt=1000", g3_c, gval, resp_c + 1); end
        checks++; if (id0 != 1 || r0 !== 32'd9 || id1 != 3 || r1 !== 32'd12) begin
            errors++; $display("[TB] FAIL held_results got %0d:%0d %0d:%0d want 1:9 3:12", id0, r0, id1, r1); end
    endtask

    task automatic test_random();
        bit [NUM_REQ-1:0] pend;
        logic [63:0]      pv [NUM_REQ];
        logic [NUM_REQ-1:0] expg;
        int               ops, t, due, own, pick, rr_last;
        bit               idle;
        logic [63:0]      oval;
        logic [65:0]      lo_sq, hi_sq, v66;
        reset_dut();
        pend = '0; ops = 0; t = 0; due = -1; own = 0; idle = 1'b1;
        rr_last = NUM_REQ - 1; oval = '0;
        for (int i = 0; i < NUM_REQ; i++) pv[i] = '0;
        while (ops < 1000 && t < 30000) begin
            next_cycle();
            t++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pv[i]   = rand_operand();
                end
                set_val(i, pv[i]);
            end
            req = pend;
            @(negedge clock);
            expg = '0;
            pick = -1;
            if (idle && pend != '0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int cnd;
                    cnd = (rr_last + k) % NUM_REQ;
                    if (pick < 0 && pend[cnd]) pick = cnd;
                end
                expg[pick] = 1'b1;
            end
            checks++; if (gnt !== expg) begin errors++; $display("[TB] FAIL rand_gnt t=%0d got %b want %b", t, gnt, expg); end
            checks++; if (busy !== !idle) begin errors++; $display("[TB] FAIL rand_busy t=%0d got %b want %b", t, busy, !idle); end
            checks++; if (resp_valid !== (t == due)) begin errors++; $display("[TB] FAIL rand_resp_valid t=%0d got %b want %b", t, resp_valid, (t == due)); end
            if (t == due) begin
                v66   = {2'b0, oval};
                lo_sq = {34'b0, resp_result} * {34'b0, resp_result};
                hi_sq = ({34'b0, resp_result} + 66'd1) * ({34'b0, resp_result} + 66'd1);
                checks++; if (!(lo_sq <= v66 && v66 < hi_sq)) begin
                    errors++; $display("[TB] FAIL rand_root v=%h got %h want %h", oval, resp_result, isqrt(oval)); end
                checks++; if (int'(resp_id) != own || resp_err !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_id got id=%0d err=%b want %0d/0", resp_id, resp_err, own); end
                ops++;
                idle = 1'b1;
                due  = -1;
            end
            if (pick >= 0) begin
                idle      = 1'b0;
                rr_last   = pick;
                own       = pick;
                oval      = pv[pick];
                pend[pick] = 1'b0;
                isr_lat   = $urandom_range(0, 6);
                due       = t + 3 + isr_lat;
            end
        end
        checks++; if (ops < 1000) begin errors++; $display("[TB] FAIL rand_completed got %0d want 1000", ops); end
        next_cycle();
        req = '0;
    endtask

`ifdef ISR_ARB_WDOG_EN
    task automatic test_wdog();
        int n;
        reset_dut();
        isr_stall = 1'b1;
        next_cycle();
        set_val(0, 64'd5);
        req = 4'b0001;
        @(negedge clock);
        next_cycle();
        req = '0;
        wait_resp(WDOG + 20, n);
        checks++; if (n != WDOG + 1 || resp_err !== 1'b1 || resp_result !== 32'd0) begin
            errors++; $display("[TB] FAIL wdog_abort got n=%0d err=%b res=%0d want %0d/1/0", n, resp_err, resp_result, WDOG + 1); end
        isr_stall = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_value  = '0;
        isr_done   = 1'b0;
        isr_result = '0;
        $display("[TB] starting isr_arbiter bench");
        test_reset();
        test_single();
        test_all_req();
        test_max();
        test_reset_mid();
        test_held_while_busy();
        test_random();
`ifdef ISR_ARB_WDOG_EN
        test_wdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
